vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system clocks per pixel; legal range 1..16.
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, each a horizontal segment length in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, each a vertical segment length in lines.
REQ-004 SHALL have parameters HS_POL 0 and VS_POL 0, each the active level of its sync pulse.
REQ-005 SHALL have parameter COLOR_W, default 4: bits per colour channel.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; the block uses one clock, and every register is clocked on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port mode, input, 2 bits: 0 colour bars, 1 grid, 2 external, 3 black.
REQ-009 SHALL have port pix_data, input, 3*COLOR_W bits: {b,g,r} pixel for external mode.
REQ-010 SHALL have output ports pix_req (1 bit), pix_x (12 bits) and pix_y (12 bits): request flag and coordinates of the pixel fetched this pixel period.
REQ-011 SHALL have output ports vga_r, vga_g, vga_b, COLOR_W bits each: colour outputs.
REQ-012 SHALL have output ports vga_hs, vga_vs and frame_start, 1 bit each: syncs and first-active-pixel pulse.

Function
REQ-013 SHALL count div_cnt 0..CLK_DIV-1 and assert pix_ce internally when div_cnt==CLK_DIV-1; with CLK_DIV=1, pix_ce SHALL be constantly 1.
REQ-014 SHALL advance all timing state only on clk edges where pix_ce=1.
REQ-015 SHALL count h_cnt 0..H_TOTAL-1 and wrap to 0, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; h_cnt=0 is the first active pixel.
REQ-016 SHALL count v_cnt 0..V_TOTAL-1, incrementing when h_cnt wraps and wrapping to 0 after V_TOTAL-1; V_TOTAL is defined the same way as H_TOTAL.
REQ-017 SHALL order the segments active, front porch, sync, back porch in both axes; h-sync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and v-sync is defined likewise.
REQ-018 SHALL drive pix_req = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE), with pix_x=h_cnt and pix_y=v_cnt zero-extended to 12 bits, all combinational from the counters.
REQ-019 SHALL sample pix_data on the pix_ce edge that ends the pixel period in which pix_req=1.
REQ-020 SHALL register all colour and sync outputs on the same pix_ce edge, giving exactly 1 pixel period of latency from counters to pins.
REQ-021 SHALL register vga_hs and vga_vs as HS_POL/VS_POL while the sync is active, and their inverse otherwise.
REQ-022 SHALL force vga_r, vga_g and vga_b to 0 whenever the sampled pix_req=0 (blanking), in every mode.
REQ-023 Mode 0 SHALL compute idx=min(pix_x/(H_ACTIVE/8),7); r, g and b are all-ones when idx[0], idx[1] and idx[2] respectively are set, else 0.
REQ-024 Mode 1 SHALL output all-ones on every channel when pix_x[3:0]==0, pix_y[3:0]==0, pix_x==H_ACTIVE-1 or pix_y==V_ACTIVE-1, else 0.
REQ-025 Mode 2 SHALL pass pix_data through to the colour outputs; mode 3 SHALL output 0.
REQ-026 SHALL latch mode into an internal mode_q only on the pix_ce edge where h_cnt=0 and v_cnt=0, so a mode change never takes effect mid-frame.
REQ-027 SHALL pulse frame_start for exactly 1 clk cycle, together with the registered output of pixel (0,0).
REQ-028 SHALL NOT let pix_x or pix_y exceed H_ACTIVE-1 or V_ACTIVE-1 while pix_req=1.

Reset
REQ-029 While rst=1, SHALL clear div_cnt, h_cnt and v_cnt to 0, load mode_q with mode, and drive colour outputs 0, frame_start 0, vga_hs=~HS_POL and vga_vs=~VS_POL.
REQ-030 After rst falls, pixel (0,0) SHALL be requested in the first pixel period, and frame_start SHALL pulse CLK_DIV clk cycles after release.
REQ-031 rst asserted mid-frame SHALL restart timing at (0,0), with no residual sync pulse on the cycle after rst.

Verification
REQ-032 Defaults, mode 0, 2 frames: hs period 1600 clks and low for 192 clks; vs period 840000 clks and low for 3200 clks; frame_start every 840000 clks.
REQ-033 Mode 0: pixel x=0 gives rgb 0/0/0; x=80 gives r=F; x=639 gives F/F/F; x=640..799 gives 0.
REQ-034 Mode 2 with pix_data = {pix_y[3:0],pix_x[7:0]}: every output pixel equals that function of its coordinates 1 pixel period later; the output is 0 in blanking.
REQ-035 Mode switched 0->1 at line 100: the current frame stays bars; the next frame shows grid with white at x=0,16,... and at y=0.
REQ-036 CLK_DIV=1 with HS_POL=1, VS_POL=1: hs period 800 clks with a 96-clk high pulse; in reset, hs=0 and vs=0.
REQ-037 rst pulsed at (x=300,y=200): the next frame_start occurs exactly CLK_DIV clks after release, and the counters read (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with built-in test patterns and an external pixel path.
// Counters drive the fetch interface combinationally; colours and syncs reach the pins one pixel period later.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   pix_data,
    output logic                   pix_req,
    output logic [11:0]            pix_x,
    output logic [11:0]            pix_y,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
    localparam logic [COLOR_W-1:0] ONES = '1;

    logic [3:0]  div_cnt;
    logic        pix_ce;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [1:0]  mode_q;
    logic [1:0]  mode_eff;
    logic        frame_first;
    logic        hs_act;
    logic        vs_act;

    // Bar index saturates at 7 so a non-multiple-of-8 width never wraps into bar 0.
    function automatic logic [2:0] bar_index(input logic [11:0] x);
        logic [11:0] q;
        q = x / 12'(BAR_W);
        return (q > 12'd7) ? 3'd7 : q[2:0];
    endfunction

    function automatic logic [3*COLOR_W-1:0] pattern(
        input logic [1:0]           md,
        input logic [11:0]          x,
        input logic [11:0]          y,
        input logic [3*COLOR_W-1:0] ext
    );
        logic [2:0]         idx;
        logic [COLOR_W-1:0] line;
        idx  = bar_index(x);
        line = ((x[3:0] == 4'd0) || (y[3:0] == 4'd0) ||
                (x == H_ACT_W - 12'd1) || (y == V_ACT_W - 12'd1)) ? ONES : '0;
        case (md)
            2'd0:    return {idx[2] ? ONES : '0, idx[1] ? ONES : '0, idx[0] ? ONES : '0};
            2'd1:    return {line, line, line};
            2'd2:    return ext;
            default: return '0;
        endcase
    endfunction

    assign pix_ce = (CLK_DIV == 1) ? 1'b1 : (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || pix_ce) begin
            div_cnt <= 4'd0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 12'd0;
                v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    assign pix_req     = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign frame_first = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    assign hs_act      = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_act      = (v_cnt >= VS_START) && (v_cnt < VS_END);
    // Pixel (0,0) already uses the newly latched mode so the whole frame is consistent.
    assign mode_eff    = frame_first ? mode : mode_q;

    // Output stage: one pixel period behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= mode;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_ce) begin
                mode_q <= mode_eff;
                if (pix_req) begin
                    {vga_b, vga_g, vga_r} <= pattern(mode_eff, h_cnt, v_cnt, pix_data);
                end else begin
                    {vga_b, vga_g, vga_r} <= '0;
                end
                vga_hs      <= hs_act ? HS_POL : ~HS_POL;
                vga_vs      <= vs_act ? VS_POL : ~VS_POL;
                frame_start <= frame_first;
            end
        end
    end

endmodule
